control_mc: RTL

Multi-cycle instruction control unit for the RV32I core, successor to the single-cycle decoder. It owns a fetch/execute/memory FSM and latches the fetched instruction into an internal instruction register. It drives variable-latency req/ack handshakes to instruction and data memory, plus the datapath selects for the register file, ALU and PC unit. Coverage extends from LUI/AUIPC/ADDI to the full RV32I integer, load/store, branch and jump set, with illegal-opcode trapping.

---
 rtl/control_mc_pkg.sv | 63 ++++++
 rtl/control_mc_imm_gen.sv | 26 ++
 rtl/control_mc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/control_mc_pkg.sv
// control_mc_pkg: shared encodings for the multi-cycle RV32I control unit
package control_mc_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_TRAP
    } state_e;

    localparam logic [1:0] REG_SEL_ALU = 2'd0;
    localparam logic [1:0] REG_SEL_MEM = 2'd1;
    localparam logic [1:0] REG_SEL_PC4 = 2'd2;

    localparam logic [1:0] PC_NEXT_SEL_INC = 2'd0;
    localparam logic [1:0] PC_NEXT_SEL_IMM = 2'd1;
    localparam logic [1:0] PC_NEXT_SEL_ALU = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // alt selects SUB over ADD and SRA over SRL
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // funct3[0] only inverts the sense, so each pair shares one compare
    function automatic logic [3:0] br_op(input logic [2:0] f3);
        return f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_EQ;
    endfunction

endpackage

// File: rtl/control_mc_imm_gen.sv
// imm_gen: sign-extended immediate for the I/S/B/U/J formats of an RV32I instruction
module imm_gen
    import control_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir_i,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opc;
    logic [31:0] imm;

    assign opc = ir_i[6:0];

    // format is chosen by opcode; anything not S/B/U/J uses the I layout
    always_comb begin
        imm = (opc == OPC_STORE)  ? {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]} :
              (opc == OPC_BRANCH) ? {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0} :
              (opc == OPC_LUI || opc == OPC_AUIPC) ? {ir_i[31:12], 12'b0} :
              (opc == OPC_JAL)    ? {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0} :
                                    {{20{ir_i[31]}}, ir_i[31:20]};
        imm_o = XLEN'($signed(imm));
    end

endmodule

// File: rtl/control_mc.sv
// control_mc: multi-cycle fetch/execute/memory control FSM for an RV32I core
module control_mc
    import control_mc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit HAS_MEM = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     instr_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [1:0]      dmem_size_o,
    input  logic            dmem_ack_i,
    input  logic            br_cond_i,
    output logic            wr_en_o,
    output logic [4:0]      rd_idx_o,
    output logic [4:0]      rs1_idx_o,
    output logic [4:0]      rs2_idx_o,
    output logic [XLEN-1:0] imm_data_o,
    output logic [3:0]      alu_op_o,
    output logic            alu_a_sel_o,
    output logic            alu_b_sel_o,
    output logic [1:0]      reg_sel_o,
    output logic            pc_wr_o,
    output logic [1:0]      pc_next_sel_o,
    output logic            illegal_o
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_op, is_opimm;
    logic        ld_ok, st_ok, br_ok, is_mem, legal, wr;

    assign opc       = ir_q[6:0];
    assign f3        = ir_q[14:12];
    assign is_lui    = opc == OPC_LUI;
    assign is_auipc  = opc == OPC_AUIPC;
    assign is_jal    = opc == OPC_JAL;
    assign is_jalr   = opc == OPC_JALR;
    assign is_branch = opc == OPC_BRANCH;
    assign is_op     = opc == OPC_OP;
    assign is_opimm  = opc == OPC_OP_IMM;
    assign ld_ok     = HAS_MEM && opc == OPC_LOAD && f3 != 3'b011 && f3[2:1] != 2'b11;
    assign st_ok     = HAS_MEM && opc == OPC_STORE && f3[2:1] != 2'b11 && !f3[2];
    assign br_ok     = is_branch && f3[2:1] != 2'b01;
    assign is_mem    = ld_ok || st_ok;
    assign legal     = is_lui || is_auipc || is_jal || is_jalr || is_op || is_opimm || br_ok || is_mem
                    || opc == OPC_MISC_MEM || opc == OPC_SYSTEM;

    assign imem_req_o = state_q == S_FETCH;
    assign dmem_req_o = state_q == S_MEM;
    assign illegal_o  = state_q == S_TRAP;
    assign rd_idx_o   = ir_q[11:7];
    assign rs1_idx_o  = is_lui ? 5'd0 : ir_q[19:15];
    assign rs2_idx_o  = ir_q[24:20];
    assign wr_en_o    = wr && ir_q[11:7] != 5'd0;

    imm_gen #(.XLEN(XLEN)) u_imm (
        .ir_i  (ir_q),
        .imm_o (imm_data_o)
    );

    // state and instruction register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // next state, IR capture and datapath controls
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        wr            = 1'b0;
        pc_wr_o       = 1'b0;
        pc_next_sel_o = PC_NEXT_SEL_INC;
        reg_sel_o     = REG_SEL_ALU;
        alu_op_o      = ALU_ADD;
        alu_a_sel_o   = 1'b0;
        alu_b_sel_o   = 1'b0;
        dmem_we_o     = 1'b0;
        dmem_size_o   = 2'b00;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = imem_ack_i ? instr_i : ir_q;
                state_d = imem_ack_i ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                state_d       = !legal ? S_TRAP : is_mem ? S_MEM : S_FETCH;
                pc_wr_o       = legal && !is_mem;
                wr            = is_lui || is_auipc || is_op || is_opimm || is_jal || is_jalr;
                alu_a_sel_o   = is_auipc;
                alu_b_sel_o   = is_lui || is_auipc || is_opimm || is_jalr || is_mem;
                alu_op_o      = is_branch ? br_op(f3) :
                                (is_op || is_opimm) ? arith_op(f3, ir_q[30] && (is_op || f3 == 3'b101)) : ALU_ADD;
                reg_sel_o     = (is_jal || is_jalr) ? REG_SEL_PC4 : REG_SEL_ALU;
                pc_next_sel_o = is_jal ? PC_NEXT_SEL_IMM : is_jalr ? PC_NEXT_SEL_ALU :
                                (is_branch && (br_cond_i ^ f3[0])) ? PC_NEXT_SEL_IMM : PC_NEXT_SEL_INC;
            end
            S_MEM: begin
                alu_b_sel_o = 1'b1;
                dmem_we_o   = opc == OPC_STORE;
                dmem_size_o = f3[1:0];
                reg_sel_o   = REG_SEL_MEM;
                wr          = dmem_ack_i && opc == OPC_LOAD;
                pc_wr_o     = dmem_ack_i;
                state_d     = dmem_ack_i ? S_FETCH : S_MEM;
            end
            default: state_d = S_TRAP;
        endcase
    end

endmodule
